// File: rtl/adbg_spr_pkg.sv
// Shared constants and types for the OR1K debug SPR slave.
// SPR window base, special register indices and FSM state encoding.
package adbg_spr_pkg;

    localparam logic [15:0] SPR_BASE = 16'h3010;
    localparam int unsigned DSR_IDX  = 4;
    localparam int unsigned DRR_IDX  = 5;
    localparam int unsigned EVT_W    = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } spr_state_t;

endpackage

// File: rtl/adbg_or1k_spr_regs.sv
// Debug SPR register bank: plain registers, masked DSR and
// sticky event DRR with write-one-to-clear (event set wins).
module adbg_or1k_spr_regs
    import adbg_spr_pkg::*;
#(
    parameter int NB_REGS = 8
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rst_i,
    input  logic                     wr_en,
    input  logic [3:0]               wr_idx,
    input  logic [31:0]              wr_data,
    input  logic [EVT_W-1:0]         evt_i,
    output logic [NB_REGS-1:0][31:0] regs_o
);

    // Register updates: DRR collects events every cycle, others on write
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            regs_o <= '0;
        end else begin
            for (int i = 0; i < NB_REGS; i++) begin
                if (i == DRR_IDX) begin
                    logic [EVT_W-1:0] clr;
                    clr = (wr_en && wr_idx == 4'(i)) ? wr_data[EVT_W-1:0] : '0;
                    regs_o[i] <= {{(32-EVT_W){1'b0}},
                                  (regs_o[i][EVT_W-1:0] & ~clr) | evt_i};
                end else if (wr_en && wr_idx == 4'(i)) begin
                    if (i == DSR_IDX)
                        regs_o[i] <= {{(32-EVT_W){1'b0}}, wr_data[EVT_W-1:0]};
                    else
                        regs_o[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/adbg_or1k_spr_slave.sv
// OR1K debug SPR slave: strobe/ack handshake onto the debug register bank.
// Optional wait states are built only when ADBG_SPR_WAIT_EN is defined.
module adbg_or1k_spr_slave
    import adbg_spr_pkg::*;
#(
    parameter int NB_REGS     = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     cpu_clk_i,
    input  logic                     cpu_rst_i,
    input  logic [15:0]              spr_addr_i,
    input  logic [31:0]              spr_data_i,
    input  logic                     spr_stb_i,
    input  logic                     spr_we_i,
    output logic [31:0]              spr_data_o,
    output logic                     spr_ack_o,
    input  logic [EVT_W-1:0]         evt_i,
    output logic [NB_REGS-1:0][31:0] regs_o,
    output logic                     unmapped_o
);

    spr_state_t  state, state_n;
    logic [15:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic [15:0] idx_q, idx_sel;
    logic        mapped_q, mapped_sel;
    logic        wr_en;
`ifdef ADBG_SPR_WAIT_EN
    logic [3:0]  cnt, cnt_n;
`else
    logic        unused_wait;
    assign unused_wait = |WAIT_CYCLES;
`endif

    assign idx_q      = addr_q - SPR_BASE;
    assign mapped_q   = idx_q < 16'(NB_REGS);
    assign idx_sel    = ((state == S_IDLE) ? spr_addr_i : addr_q) - SPR_BASE;
    assign mapped_sel = idx_sel < 16'(NB_REGS);
    assign wr_en      = (state == S_ACK) && we_q && mapped_q;
    assign spr_ack_o  = (state == S_ACK);
    assign spr_data_o = spr_ack_o ? rdata_q : 32'h0;

    // Next-state logic for the strobe/wait/ack handshake
    always_comb begin
        state_n = state;
`ifdef ADBG_SPR_WAIT_EN
        cnt_n = cnt;
`endif
        unique case (state)
            S_IDLE: begin
                if (spr_stb_i) begin
`ifdef ADBG_SPR_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_n = S_WAIT;
                        cnt_n   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_n = S_ACK;
                    end
`else
                    state_n = S_ACK;
`endif
                end
            end
`ifdef ADBG_SPR_WAIT_EN
            S_WAIT: begin
                if (!spr_stb_i)
                    state_n = S_IDLE;
                else if (cnt == 4'd0)
                    state_n = S_ACK;
                else
                    cnt_n = cnt - 4'd1;
            end
`endif
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Read data selected from the (captured or incoming) address
    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < NB_REGS; i++)
            if (mapped_sel && idx_sel == 16'(i))
                rd_mux = regs_o[i];
    end

    // State, request capture, read data and sticky unmapped flag
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
            unmapped_o <= 1'b0;
`ifdef ADBG_SPR_WAIT_EN
            cnt        <= '0;
`endif
        end else begin
            state <= state_n;
`ifdef ADBG_SPR_WAIT_EN
            cnt   <= cnt_n;
`endif
            if (state == S_IDLE && spr_stb_i) begin
                addr_q <= spr_addr_i;
                data_q <= spr_data_i;
                we_q   <= spr_we_i;
            end
            if (state_n == S_ACK && state != S_ACK)
                rdata_q <= rd_mux;
            if (state == S_ACK && !mapped_q)
                unmapped_o <= 1'b1;
        end
    end

    adbg_or1k_spr_regs #(
        .NB_REGS (NB_REGS)
    ) u_regs (
        .cpu_clk_i (cpu_clk_i),
        .cpu_rst_i (cpu_rst_i),
        .wr_en     (wr_en),
        .wr_idx    (idx_q[3:0]),
        .wr_data   (data_q),
        .evt_i     (evt_i),
        .regs_o    (regs_o)
    );

endmodule

// File: tb/tb_adbg_or1k_spr_slave.sv
// Directed self-checking bench for adbg_or1k_spr_slave.
// Expected latency follows ADBG_SPR_WAIT_EN.
module tb_adbg_or1k_spr_slave;

    localparam int NB = 8;
    localparam int WC = 2;
`ifdef ADBG_SPR_WAIT_EN
    localparam int LAT = WC + 1;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [15:0]      addr = '0;
    logic [31:0]      wdata = '0;
    logic             stb = 1'b0;
    logic             we = 1'b0;
    logic [31:0]      rdata;
    logic             ack;
    logic [13:0]      evt = '0;
    logic [NB-1:0][31:0] regs;
    logic             unmapped;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adbg_or1k_spr_slave #(
        .NB_REGS     (NB),
        .WAIT_CYCLES (WC)
    ) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_i  (rst),
        .spr_addr_i (addr),
        .spr_data_i (wdata),
        .spr_stb_i  (stb),
        .spr_we_i   (we),
        .spr_data_o (rdata),
        .spr_ack_o  (ack),
        .evt_i      (evt),
        .regs_o     (regs),
        .unmapped_o (unmapped)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts at #1 after a posedge; returns at #1 after the edge ending ACK
    task automatic spr_access(input logic [15:0] a, input logic w,
                              input logic [31:0] d,
                              output logic [31:0] rd, output int lat);
        addr = a;
        we = w;
        wdata = d;
        stb = 1'b1;
        lat = 0;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ack) break;
        end
        if (!ack) check("ack_timeout", 32'(ack), 32'd1);
        rd = rdata;
        stb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    int          lat;
    int          acks;

    initial begin
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", rdata, 32'h0);
        check("rst_unmapped", 32'(unmapped), 32'd0);
        check("rst_reg0", regs[0], 32'h0);
        check("rst_drr", regs[5], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        spr_access(16'h3010, 1'b1, 32'hDEADBEEF, rd, lat);
        check("wr_lat", 32'(lat), 32'(LAT));
        check("wr_reg0", regs[0], 32'hDEADBEEF);

        spr_access(16'h3010, 1'b0, 32'h0, rd, lat);
        check("rd_lat", 32'(lat), 32'(LAT));
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_after", rdata, 32'h0);

        spr_access(16'h3012, 1'b1, 32'hA5A50F0F, rd, lat);
        spr_access(16'h3012, 1'b0, 32'h0, rd, lat);
        check("rd_reg2", rd, 32'hA5A50F0F);

        spr_access(16'h3017, 1'b1, 32'h13572468, rd, lat);
        check("wr_reg7", regs[7], 32'h13572468);

        spr_access(16'h3014, 1'b1, 32'hFFFFFFFF, rd, lat);
        check("dsr_mask", regs[4], 32'h00003FFF);
        spr_access(16'h3014, 1'b0, 32'h0, rd, lat);
        check("dsr_rd", rd, 32'h00003FFF);

        evt = 14'h0005;
        @(posedge clk);
        #1;
        evt = 14'h0000;
        check("drr_evt", regs[5], 32'h5);
        evt = 14'h0001;
        spr_access(16'h3015, 1'b1, 32'h1, rd, lat);
        evt = 14'h0000;
        check("drr_set_wins", regs[5], 32'h5);
        spr_access(16'h3015, 1'b1, 32'h5, rd, lat);
        check("drr_w1c", regs[5], 32'h0);
        spr_access(16'h3015, 1'b1, 32'hFFFFC000, rd, lat);
        check("drr_hi_zero", regs[5], 32'h0);
        check("unmapped_pre", 32'(unmapped), 32'd0);

        spr_access(16'h3100, 1'b0, 32'h0, rd, lat);
        check("unm_rd_lat", 32'(lat), 32'(LAT));
        check("unm_rd_data", rd, 32'h0);
        check("unmapped_set", 32'(unmapped), 32'd1);
        spr_access(16'h3018, 1'b1, 32'h00001234, rd, lat);
        spr_access(16'h300F, 1'b1, 32'h00005678, rd, lat);
        check("unm_wr_reg0", regs[0], 32'hDEADBEEF);
        check("unm_wr_reg7", regs[7], 32'h13572468);
        spr_access(16'h3011, 1'b0, 32'h0, rd, lat);
        check("unmapped_sticky", 32'(unmapped), 32'd1);

        addr = 16'h3011;
        we = 1'b1;
        wdata = 32'h11110001;
        stb = 1'b1;
        acks = 0;
        for (int i = 0; i < 20 && acks < 2; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acks++;
                addr = 16'h3013;
                wdata = 32'h33330003;
                if (acks == 2) stb = 1'b0;
            end
        end
        stb = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_acks", 32'(acks), 32'd2);
        check("b2b_reg1", regs[1], 32'h11110001);
        check("b2b_reg3", regs[3], 32'h33330003);

`ifdef ADBG_SPR_WAIT_EN
        addr = 16'h3011;
        we = 1'b1;
        wdata = 32'h00001234;
        stb = 1'b1;
        acks = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        addr = 16'h3016;
        wdata = 32'hBAD0BAD0;
        stb = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        check("abort_noack", 32'(acks), 32'd0);
        check("abort_reg1", regs[1], 32'h11110001);
        check("abort_reg6", regs[6], 32'h0);
`endif

        addr = 16'h3010;
        we = 1'b1;
        wdata = 32'h0BADF00D;
        stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        stb = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_data", rdata, 32'h0);
        check("mid_rst_reg0", regs[0], 32'h0);
        check("mid_rst_unm", 32'(unmapped), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        check("post_rst_noack", 32'(acks), 32'd0);
        check("post_rst_reg0", regs[0], 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        spr_access(16'h3012, 1'b1, 32'hCAFEF00D, rd, lat);
        check("first_acc_lat", 32'(lat), 32'(LAT));
        check("first_acc_reg2", regs[2], 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adbg_or1k_spr_slave.md
ADBG_OR1K_SPR_SLAVE -- requirements
Module: adbg_or1k_spr_slave

Interface
REQ-001 SHALL have parameter NB_REGS, default 8: number of debug SPRs implemented at 16'h3010 .. 16'h3010+NB_REGS-1; legal range 6..16.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: extra wait states before ack; legal range 0..15.
REQ-003 cpu_clk_i  in  1: single clock; all logic on its rising edge.
REQ-004 cpu_rst_i  in  1: asynchronous, active-high reset.
REQ-005 spr_addr_i  in  16: SPR address from the debug initiator.
REQ-006 spr_data_i  in  32: write data.
REQ-007 spr_stb_i  in  1: access strobe, held high by the initiator until it sees ack.
REQ-008 spr_we_i  in  1: 1 = write, 0 = read.
REQ-009 spr_data_o  out  32: read data; valid only while spr_ack_o = 1, 0 otherwise.
REQ-010 spr_ack_o  out  1: one-cycle completion pulse.
REQ-011 evt_i  in  14: hardware debug events, sticky-set into DRR.
REQ-012 regs_o  out  NB_REGS x 32: live contents of all implemented SPRs.
REQ-013 unmapped_o  out  1: sticky flag, set by any access outside the implemented range.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and ACK.
REQ-015 IDLE with spr_stb_i=1: go to WAIT when the wait counter feature is active and WAIT_CYCLES>0; otherwise go to ACK.
REQ-016 WAIT SHALL load the counter with WAIT_CYCLES-1 on entry and decrement it each cycle; at 0 go to ACK.
REQ-017 ACK SHALL drive spr_ack_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-018 Latency from the first cycle spr_stb_i is sampled high in IDLE to spr_ack_o=1 SHALL be WAIT_CYCLES+1 cycles (1 without the macro).
REQ-019 If spr_stb_i falls in WAIT: abort to IDLE; no ack, no write, no flag update.
REQ-020 spr_addr_i, spr_we_i and spr_data_i SHALL be captured when leaving IDLE; later changes are ignored.
REQ-021 A write SHALL commit on the clock edge that ends the ACK cycle.
REQ-022 Read data SHALL be registered on entry to ACK from the captured address.
REQ-023 Index = captured address - 16'h3010.
REQ-024 Index 5 (DRR, 16'h3015): each cycle DRR[13:0] |= evt_i; a write clears the bits written as 1 (W1C); DRR[31:14] reads 0.
REQ-025 Simultaneous evt_i set and W1C on the same bit: set SHALL win.
REQ-026 Index 4 (DSR): bits [31:14] read 0 and ignore writes.
REQ-027 All other implemented indices: plain 32-bit read/write.
REQ-028 An unmapped read SHALL ack with data 0; an unmapped write SHALL ack with no effect; both set unmapped_o.
REQ-029 unmapped_o clears only on reset.
REQ-030 After ACK, spr_stb_i still high in IDLE SHALL start a new access.

Reset
REQ-031 cpu_rst_i=1 SHALL asynchronously force: FSM=IDLE, counter=0, spr_ack_o=0, spr_data_o=0, all SPRs=0, unmapped_o=0.
REQ-032 Reset mid-access SHALL drop the access; no ack follows deassertion.
REQ-033 The first access SHALL be accepted in the first cycle after reset deasserts.

Configuration
REQ-034 Macro ADBG_SPR_WAIT_EN defined: WAIT state and 4-bit counter are built and WAIT_CYCLES is honoured.
REQ-035 ADBG_SPR_WAIT_EN undefined: no WAIT state or counter, WAIT_CYCLES is ignored, and the path is always IDLE->ACK (latency 1).

Structure
REQ-036 Shared package adbg_spr_pkg SHALL hold: SPR base 16'h3010, DSR/DRR index constants, DRR event width (14), FSM state typedef.
REQ-037 One sub-module, adbg_or1k_spr_regs (register bank with DRR set/W1C logic), is natural; the FSM stays in the top level.

Verification
REQ-038 Write 32'hDEADBEEF to 16'h3010, WAIT_CYCLES=2, macro on -> ack in cycle 3 after stb; regs_o[0]=32'hDEADBEEF.
REQ-039 Read 16'h3010 after REQ-038 -> spr_data_o=32'hDEADBEEF during the single ack cycle, 0 before and after.
REQ-040 evt_i=14'h0005 for one cycle, then write 32'h1 to 16'h3015 in the same cycle evt_i=14'h0001 -> DRR=32'h5; next W1C 32'h5 with evt_i=0 -> DRR=0.
REQ-041 Read 16'h3100 -> ack, data 0, unmapped_o=1 and stays 1.
REQ-042 stb dropped in the second WAIT cycle of a write of 32'h1234 to 16'h3011 -> no ack, regs_o[1] unchanged.
REQ-043 Macro off -> ack exactly 1 cycle after stb for any WAIT_CYCLES; cpu_rst_i pulsed during WAIT (macro on) -> all outputs 0, no ack afterwards.
